// File: rtl/dmac_wr_engine.sv
// Write-side DMA engine: drains the data FIFO into AXI4 INCR write bursts,
// splitting at MAX_BURST beats and at 4 KB pages, one burst outstanding at a time.
module dmac_wr_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     dst_addr_i,
  input  logic [LEN_WIDTH-1:0]      byte_len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  input  logic                      fifo_empty_i,
  output logic                      fifo_rden_o,
  input  logic [DATA_WIDTH-1:0]     fifo_rdata_i,
  output logic [ADDR_WIDTH-1:0]     awaddr_o,
  output logic [3:0]                awlen_o,
  output logic [2:0]                awsize_o,
  output logic [1:0]                awburst_o,
  output logic                      awvalid_o,
  input  logic                      awready_i,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH/8-1:0]   wstrb_o,
  output logic                      wlast_o,
  output logic                      wvalid_o,
  input  logic                      wready_i,
  input  logic [1:0]                bresp_i,
  input  logic                      bvalid_i,
  output logic                      bready_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, CALC, AW, W, B} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
  logic [LEN_WIDTH-1:0]    rem_reg, rem_next;
  logic [3:0]              beat_reg, beat_next;
  logic [3:0]              awlen_reg, awlen_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    err_reg, err_next;

  logic [LEN_WIDTH-1:0]    rem_beats;
  logic [12:0]             page_beats;
  logic [4:0]              calc_beats;
  logic [ADDR_WIDTH-1:0]   burst_addr_bytes;
  logic [LEN_WIDTH-1:0]    burst_len_bytes;
  logic                    wvalid;
  logic                    w_hs;

  // Beats left before the page end bound the burst so it never crosses 4 KB.
  assign rem_beats  = rem_reg >> BSH;
  assign page_beats = (13'd4096 - {1'b0, addr_reg[11:0]}) >> BSH;

  always_comb begin
    calc_beats = 5'(MAX_BURST);
    if (rem_beats < LEN_WIDTH'(MAX_BURST))
      calc_beats = 5'(rem_beats);
    if (page_beats < 13'(calc_beats))
      calc_beats = 5'(page_beats);
  end

  assign burst_addr_bytes = ADDR_WIDTH'({1'b0, awlen_reg} + 5'd1) << BSH;
  assign burst_len_bytes  = LEN_WIDTH'({1'b0, awlen_reg} + 5'd1) << BSH;

  assign wvalid = (state_reg == W) && !fifo_empty_i;
  assign w_hs   = wvalid && wready_i;

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign fifo_rden_o = w_hs;
  assign awaddr_o    = awaddr_reg;
  assign awlen_o     = awlen_reg;
  assign awsize_o    = 3'(BSH);
  assign awburst_o   = 2'b01;
  assign awvalid_o   = (state_reg == AW);
  assign wdata_o     = fifo_rdata_i;
  assign wstrb_o     = '1;
  assign wvalid_o    = wvalid;
  assign wlast_o     = wvalid && (beat_reg == awlen_reg);
  assign bready_o    = (state_reg == B);

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    awaddr_next = awaddr_reg;
    rem_next    = rem_reg;
    beat_next   = beat_reg;
    awlen_next  = awlen_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          addr_next = dst_addr_i;
          rem_next  = byte_len_i;
          err_next  = 1'b0;
          if (byte_len_i == '0) begin
            done_next = 1'b1;
          end else begin
            busy_next  = 1'b1;
            state_next = CALC;
          end
        end
      end
      CALC: begin
        awlen_next  = 4'(calc_beats - 5'd1);
        awaddr_next = addr_reg;
        state_next  = AW;
      end
      AW: begin
        if (awready_i) begin
          beat_next  = 4'd0;
          state_next = W;
        end
      end
      W: begin
        if (w_hs) begin
          beat_next = beat_reg + 4'd1;
          if (beat_reg == awlen_reg) begin
            addr_next  = addr_reg + burst_addr_bytes;
            rem_next   = rem_reg - burst_len_bytes;
            state_next = B;
          end
        end
      end
      B: begin
        if (bvalid_i) begin
          if (bresp_i != 2'b00)
            err_next = 1'b1;
          if (rem_reg != '0) begin
            state_next = CALC;
          end else begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      awaddr_reg <= '0;
      rem_reg    <= '0;
      beat_reg   <= '0;
      awlen_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      awaddr_reg <= awaddr_next;
      rem_reg    <= rem_next;
      beat_reg   <= beat_next;
      awlen_reg  <= awlen_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

endmodule

// File: doc/dmac_wr_engine.md
Name: dmac_wr_engine

Overview:
Write-side engine of the DMA controller, directly downstream of the DMA data FIFO.
- Pops words from the FIFO and issues AXI4 INCR write bursts (AW/W/B) to the destination address until the programmed byte count is transferred.
- Splits the transfer into bursts of at most MAX_BURST beats, never crossing a 4 KB boundary.
- Reports completion with done_o and a sticky error flag.

Parameters:
ADDR_WIDTH, 32, destination address width
DATA_WIDTH, 32, data/beat width; must match the FIFO data width; beat size = DATA_WIDTH/8 bytes
LEN_WIDTH, 16, byte-count width
MAX_BURST, 16, maximum beats per burst (power of 2, ≤16)

Ports:
Clock and reset (already decided): one clock; reset is asynchronous and active-low.
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle start pulse; sampled only in IDLE
dst_addr_i  in  ADDR_WIDTH  destination byte address, beat-aligned; sampled with start_i
byte_len_i  in  LEN_WIDTH  byte count, multiple of DATA_WIDTH/8; sampled with start_i
busy_o  in  —  see below; out 1: high from the cycle after accepted start until done_o
done_o  out  1  one-cycle pulse when the transfer completes
err_o  out  1  sticky; set on any bresp≠OKAY; cleared on the next accepted start
fifo_empty_i  in  1  FIFO empty flag
fifo_rden_o  out  1  FIFO pop
fifo_rdata_i  in  DATA_WIDTH  FIFO head word (combinational from FIFO)
awaddr_o  out  ADDR_WIDTH  burst address
awlen_o  out  4  beats−1
awsize_o  out  3  constant log2(DATA_WIDTH/8)
awburst_o  out  2  constant 2'b01 (INCR)
awvalid_o  out  1  AW valid
awready_i  in  1  AW ready
wdata_o  out  DATA_WIDTH  equals fifo_rdata_i
wstrb_o  out  DATA_WIDTH/8  all ones
wlast_o  out  1  final beat of the burst
wvalid_o  out  1  W valid
wready_i  in  1  W ready
bresp_i  in  2  write response
bvalid_i  in  1  B valid
bready_o  out  1  B ready

Behaviour:
- Reset: state=IDLE; busy_o, done_o, err_o, awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o = 0; awaddr_o, awlen_o, and counters = 0. Reset takes effect immediately, including mid-burst; no pending AXI transaction is completed.
- Registers: addr (ADDR_WIDTH), remaining bytes (LEN_WIDTH), beat counter (4 bits), burst length (4 bits).
- State machine: IDLE → CALC → AW → W → B → (CALC | IDLE).
  - IDLE: on start_i, latch dst_addr_i, byte_len_i and clear err_o.
    - byte_len_i = 0: done_o pulses the next cycle and the state stays IDLE.
    - Otherwise go to CALC with busy_o = 1.
  - CALC (1 cycle): beats = min(MAX_BURST, remaining/BYTES, (4096 − addr[11:0])/BYTES). Register awlen = beats−1 and awaddr = addr, then go to AW.
  - AW: awvalid_o = 1. awaddr_o and awlen_o are held stable until awready_i. On handshake go to W with beat counter = 0.
  - W: wvalid_o = ~fifo_empty_i. fifo_rden_o = wvalid_o & wready_i (same cycle, no skid). wlast_o = wvalid_o & (beat counter == awlen). On each handshake the beat counter increments. On the last handshake: addr += beats×BYTES, remaining −= beats×BYTES, go to B.
    - wvalid_o never asserts while the FIFO is empty.
    - wdata_o may change only after a pop.
  - B: bready_o = 1. On bvalid_i, err_o |= (bresp_i ≠ 2'b00).
    - If remaining ≠ 0, go to CALC.
    - Otherwise pulse done_o, drop busy_o, and go to IDLE.
- An error does not abort the transfer; all bytes are still written.
- start_i outside IDLE is ignored.
- No W beat is issued before its AW handshake; at most one burst is outstanding.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no 4 KB crossing by construction.

Test Plan:
- Single burst: start, dst=0x1000, len=64, FIFO pre-filled with 16 words 0..15, ready always high → one AW (addr 0x1000, awlen=15), 16 W beats of data 0..15, wlast on beat 16, done_o pulses one cycle after the B handshake.
- Multi-burst split: dst=0x2000, len=136 → bursts of awlen 15, 15, 1 at 0x2000, 0x2040, 0x2080; 34 pops total.
- 4 KB boundary: dst=0x0FF0, len=32 → AW 0x0FF0 with awlen=3, then AW 0x1000 with awlen=3.
- FIFO starvation/backpressure: FIFO empty for 5 cycles mid-burst and wready_i toggling → wvalid_o=0 while empty; no pop without a handshake; data order preserved.
- Error plus zero length: bresp=2'b10 on the first of 2 bursts → both bursts complete and err_o=1 at done_o. A later start with len=0 → err_o cleared, done_o one cycle later, no AXI activity.
- Reset mid-W: assert rst_n=0 on beat 5 → awvalid_o, wvalid_o, fifo_rden_o and busy_o drop immediately (asynchronously); after release the block is IDLE and accepts a new start.
